// File: rtl/lfsr_seg_pkg.sv
// Shared constants for the LFSR seven-segment generator: active-low hex glyphs,
// the blank pattern and default feedback masks per supported width.
package lfsr_seg_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;

  // Active-low, bit order {a,b,c,d,e,f,g} with a in the MSB
  localparam seg7_t SEG_GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  localparam logic [3:0]  TAPS_W4  = 4'h3;
  localparam logic [7:0]  TAPS_W8  = 8'h1D;
  localparam logic [15:0] TAPS_W16 = 16'h002D;
  localparam logic [31:0] TAPS_W32 = 32'h0000_00C5;

  function automatic logic [31:0] default_taps(input int unsigned width);
    case (width)
      4:       return 32'(TAPS_W4);
      8:       return 32'(TAPS_W8);
      16:      return 32'(TAPS_W16);
      default: return TAPS_W32;
    endcase
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
  import lfsr_seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    seg = SEG_GLYPH[hex];
  end

endmodule

// File: rtl/lfsr_seg_gen.sv
// Parametrised Fibonacci LFSR with step/run advance, parallel load and hex
// seven-segment outputs. Optional period/wrap tracking under LFSR_SEG_PERIOD_EN.
module lfsr_seg_gen
  import lfsr_seg_pkg::*;
#(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(8'h1D),
  parameter logic [WIDTH-1:0] SEED   = WIDTH'(1),
  parameter int unsigned      DIV    = 1,
  parameter int unsigned      DIGITS = WIDTH / 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step,
  input  logic                  run,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  output logic [WIDTH-1:0]      q,
  output logic [7*DIGITS-1:0]   seg
`ifdef LFSR_SEG_PERIOD_EN
  ,
  output logic [WIDTH-1:0]      period,
  output logic                  wrap
`endif
);

  localparam int unsigned       CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);

  logic [WIDTH-1:0] lfsr_q, lfsr_d, shift_nxt;
  logic             step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_rise, tick, advance, is_zero;

  always_comb begin
    step_rise = step & ~step_q;
    tick      = run & (cnt_q == CNT_LAST);
    advance   = step_rise | tick;
    is_zero   = (lfsr_q == '0);
    shift_nxt = {^(lfsr_q & TAPS), lfsr_q[WIDTH-1:1]};
    step_d    = step;
    cnt_d     = (run && !tick) ? cnt_q + 1'b1 : '0;
    if (load)         lfsr_d = load_val;
    else if (is_zero) lfsr_d = SEED;
    else if (advance) lfsr_d = shift_nxt;
    else              lfsr_d = lfsr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
      step_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      step_q <= step_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q = lfsr_q;

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    hex_to_seg7 u_hex (
      .hex (lfsr_q[4*d +: 4]),
      .seg (seg[7*d +: 7])
    );
  end

`ifdef LFSR_SEG_PERIOD_EN
  logic [WIDTH-1:0] step_cnt_q, step_cnt_d, period_q, period_d;
  logic             wrap_q, wrap_d;

  // Only advances that actually reach the register count toward the period
  always_comb begin
    step_cnt_d = step_cnt_q;
    period_d   = period_q;
    wrap_d     = 1'b0;
    if (load || is_zero) begin
      step_cnt_d = '0;
    end else if (advance) begin
      if (shift_nxt == SEED) begin
        period_d   = step_cnt_q + 1'b1;
        wrap_d     = 1'b1;
        step_cnt_d = '0;
      end else if (step_cnt_q != '1) begin
        step_cnt_d = step_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt_q <= '0;
      period_q   <= '0;
      wrap_q     <= 1'b0;
    end else begin
      step_cnt_q <= step_cnt_d;
      period_q   <= period_d;
      wrap_q     <= wrap_d;
    end
  end

  assign period = period_q;
  assign wrap   = wrap_q;
`endif

endmodule

// File: tb/tb_lfsr_seg_gen.sv
// Self-checking bench for lfsr_seg_gen: an 8-bit DIV=4 instance and a 4-bit
// DIV=1 instance checked every cycle against a behavioural model.
module tb_lfsr_seg_gen;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] cnt;
    logic [31:0] per;
    logic        wrap;
    logic        prev;
    logic [31:0] age;
  } mstate_t;

  localparam logic [6:0] GLY [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic clk, rst;
  logic s0, r0, l0, s1, r1, l1;
  logic [7:0]  lv0, q0, per0;
  logic [13:0] seg0;
  logic [3:0]  lv1, q1, per1;
  logic [6:0]  seg1;
  logic        wrap0, wrap1;
  logic        cmp_en;
  int unsigned n_assert, n_fail;
  mstate_t     m [2];

  lfsr_seg_gen #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'h01), .DIV(4)) u_dut8 (
    .clk(clk), .rst(rst), .step(s0), .run(r0), .load(l0), .load_val(lv0),
    .q(q0), .seg(seg0)
`ifdef LFSR_SEG_PERIOD_EN
    , .period(per0), .wrap(wrap0)
`endif
  );

  lfsr_seg_gen #(.WIDTH(4), .TAPS(4'h3), .SEED(4'h1), .DIV(1)) u_dut4 (
    .clk(clk), .rst(rst), .step(s1), .run(r1), .load(l1), .load_val(lv1),
    .q(q1), .seg(seg1)
`ifdef LFSR_SEG_PERIOD_EN
    , .period(per1), .wrap(wrap1)
`endif
  );

`ifndef LFSR_SEG_PERIOD_EN
  assign per0 = '0; assign wrap0 = 1'b0;
  assign per1 = '0; assign wrap1 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: LFSR step as shift-right with parity of tapped bits in the MSB
  function automatic logic [31:0] lfsr_next(input logic [31:0] v, input logic [31:0] taps,
                                            input int unsigned w);
    logic fb;
    fb = ^(v & taps);
    return (v >> 1) | (32'(fb) << (w - 1));
  endfunction

  function automatic logic [27:0] seg_of(input logic [31:0] v, input int unsigned digits);
    logic [27:0] r;
    r = '1;
    for (int unsigned d = 0; d < digits; d++) r[7*d +: 7] = GLY[v[4*d +: 4]];
    return r;
  endfunction

  function automatic mstate_t model_next(input int unsigned i, input mstate_t s, input logic st,
                                         input logic rn, input logic ld, input logic [31:0] lv);
    mstate_t     n;
    int unsigned w, dv;
    logic [31:0] taps, seed, full, nx;
    logic        adv;
    w    = (i == 0) ? 8 : 4;
    dv   = (i == 0) ? 4 : 1;
    taps = (i == 0) ? 32'h1D : 32'h3;
    seed = 32'h1;
    full = (32'h1 << w) - 1;
    n = s;
    n.wrap = 1'b0;
    adv = (st && !s.prev) || (rn && ((s.age % dv) == dv - 1));
    if (ld) begin
      n.q = lv; n.cnt = 0;
    end else if (s.q == 0) begin
      n.q = seed; n.cnt = 0;
    end else if (adv) begin
      nx = lfsr_next(s.q, taps, w);
      if (nx == seed) begin
        n.per = s.cnt + 1; n.wrap = 1'b1; n.cnt = 0;
      end else if (s.cnt != full) begin
        n.cnt = s.cnt + 1;
      end
      n.q = nx;
    end
    n.age  = rn ? s.age + 1 : 0;
    n.prev = st;
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m[0] <= '{q: 32'h1, default: '0};
      m[1] <= '{q: 32'h1, default: '0};
    end else begin
      m[0] <= model_next(0, m[0], s0, r0, l0, 32'(lv0));
      m[1] <= model_next(1, m[1], s1, r1, l1, 32'(lv1));
    end
  end

  always @(negedge clk) begin
    logic [27:0] e0, e1;
    if (cmp_en) begin
      e0 = seg_of(m[0].q, 2);
      e1 = seg_of(m[1].q, 1);
      chk("model_q8", 32'(q0), m[0].q);
      chk("model_seg8", 32'(seg0), 32'(e0[13:0]));
      chk("model_q4", 32'(q1), m[1].q);
      chk("model_seg4", 32'(seg1), 32'(e1[6:0]));
`ifdef LFSR_SEG_PERIOD_EN
      chk("model_period8", 32'(per0), m[0].per);
      chk("model_wrap8", 32'(wrap0), 32'(m[0].wrap));
      chk("model_period4", 32'(per1), m[1].per);
      chk("model_wrap4", 32'(wrap1), 32'(m[1].wrap));
`endif
    end
  end

  initial begin
    logic [7:0]  step_exp [5];
    logic [15:0] seen;
    int unsigned ones;
    step_exp = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
    n_assert = 0; n_fail = 0; cmp_en = 1'b0;
    rst = 1'b1; s0 = 0; r0 = 0; l0 = 0; lv0 = '0; s1 = 0; r1 = 0; l1 = 0; lv1 = '0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    rst = 1'b0;
    chk("reset_q8", 32'(q0), 32'h01);
    chk("reset_seg_d0", 32'(seg0[6:0]), 32'(7'b1001111));
    chk("reset_seg_d1", 32'(seg0[13:7]), 32'(7'b0000001));
    chk("reset_q4", 32'(q1), 32'h1);

    for (int k = 0; k < 5; k++) begin
      s0 = 1'b1; @(negedge clk);
      s0 = 1'b0; @(negedge clk);
      chk("step_pulse", 32'(q0), 32'(step_exp[k]));
    end

    s0 = 1'b1; repeat (10) @(negedge clk);
    s0 = 1'b0; @(negedge clk);
    chk("step_held_once", 32'(q0), 32'hC4);

    repeat (4) begin
      s0 = 1'b1; @(negedge clk);
      s0 = 1'b0; @(negedge clk);
    end
    chk("step_toggle_x4", 32'(q0), 32'h1C);

    l0 = 1'b1; lv0 = 8'h00; @(negedge clk);
    l0 = 1'b0;
    chk("load_zero", 32'(q0), 32'h00);
    @(negedge clk);
    chk("zero_recover", 32'(q0), 32'h01);

    l0 = 1'b1; lv0 = 8'hA5; s0 = 1'b1; @(negedge clk);
    l0 = 1'b0; s0 = 1'b0;
    chk("load_beats_step", 32'(q0), 32'hA5);
    @(negedge clk);
    chk("load_no_late_adv", 32'(q0), 32'hA5);
    chk("seg_A5_d0", 32'(seg0[6:0]), 32'(7'b0100100));
    chk("seg_A5_d1", 32'(seg0[13:7]), 32'(7'b0001000));

    seen = '0;
    r1 = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      seen[q1] = 1'b1;
      if (k == 1) chk("run4_first", 32'(q1), 32'h8);
    end
    r1 = 1'b0;
    chk("run4_return_seed", 32'(q1), 32'h1);
    ones = 0;
    for (int b = 1; b < 16; b++) ones += 32'(seen[b]);
    chk("run4_distinct", ones, 15);
    chk("run4_no_zero", 32'(seen[0]), 0);
`ifdef LFSR_SEG_PERIOD_EN
    chk("period4", 32'(per1), 15);
    chk("wrap4_high", 32'(wrap1), 1);
`endif
    @(negedge clk);
    chk("run4_stop", 32'(q1), 32'h1);
`ifdef LFSR_SEG_PERIOD_EN
    chk("wrap4_one_cycle", 32'(wrap1), 0);
`endif

    r0 = 1'b1;
    repeat (3) @(negedge clk);
    chk("div4_wait", 32'(q0), 32'hA5);
    @(negedge clk);
    chk("div4_tick1", 32'(q0), 32'h52);
    repeat (4) @(negedge clk);
    chk("div4_tick2", 32'(q0), 32'hA9);
    repeat (2) @(negedge clk);
    r0 = 1'b0;
    repeat (3) @(negedge clk);
    r0 = 1'b1;
    repeat (3) @(negedge clk);
    chk("div4_rerun_wait", 32'(q0), 32'hA9);
    @(negedge clk);
    chk("div4_rerun_tick", 32'(q0), 32'h54);

    l0 = 1'b1; lv0 = 8'h33; rst = 1'b1; @(negedge clk);
    rst = 1'b0; l0 = 1'b0;
    chk("rst_over_load", 32'(q0), 32'h01);
`ifdef LFSR_SEG_PERIOD_EN
    chk("rst_period", 32'(per0), 0);
    chk("rst_wrap", 32'(wrap0), 0);
`endif
    repeat (3) @(negedge clk);
    chk("rst_cnt_cleared", 32'(q0), 32'h01);
    @(negedge clk);
    chk("rst_first_tick", 32'(q0), 32'h80);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
